quad_dir_counter: RTL and testbench
===================================

// Module: quad_dir_counter
// PURPOSE
//  Parametrised two-channel direction sensor decoder, the successor of the in/in1 turn detector.
//  Synchronises and debounces two sensor lines, decodes Gray-sequence steps into CW/CCW pulses,
//  keeps a signed position count and drives a rotating one-hot LED bar (p1..p8 style, width NUM_LED).
//  Sits between the board sensor pins and the display/indicator logic.
// PARAMETERS
//  DEB_CYCLES  4   consecutive equal samples needed before a synchronised input is accepted (>=1)
//  POS_W       8   width of position counter (two's complement)
//  NUM_LED     8   width of one-hot LED output (>=2, need not be a power of two)
//  WRAP        1   1: position wraps modulo 2^POS_W; 0: saturates at min/max signed value
// PORTS
//  sys_clk   in   1        system clock, all logic on rising edge
//  sys_rst   in   1        synchronous reset, active-high
//  in_a      in   1        raw sensor channel A (asynchronous)
//  in_b      in   1        raw sensor channel B (asynchronous)
//  clr       in   1        synchronous clear of position and LED index
//  step_cw   out  1        one-cycle pulse per legal CW transition
//  step_ccw  out  1        one-cycle pulse per legal CCW transition
//  dir       out  1        direction of last legal step (1=CW, 0=CCW)
//  err       out  1        one-cycle pulse on illegal transition (both channels changed)
//  sat       out  1        high while position is held at a limit (WRAP=0 only, else 0)
//  pos       out  POS_W    signed position count
//  led       out  NUM_LED  one-hot LED bar, led[idx]
// BEHAVIOUR
//  Reset (sys_rst=1 at edge): all outputs 0 except led=1 (bit0); idx=0; sync/filter regs = 00;
//   debounce counters 0. Reset overrides every other input including clr.
//  Sync: 2-FF synchroniser per channel.
//  Debounce per channel: counter resets whenever sync value == filtered value; otherwise
//   increments; when it reaches DEB_CYCLES-1 filtered value takes sync value, counter clears.
//   A glitch shorter than DEB_CYCLES cycles never reaches the filter.
//  Decoder: state S = filtered {a,b}, prev state P registered each cycle.
//   CW sequence 00->01->11->10->00; CCW is the reverse.
//   S==P: no action. Legal CW: step_cw=1, dir<=1, pos+1, idx+1. Legal CCW: step_ccw=1,
//   dir<=0, pos-1, idx-1. Both bits changed (00<->11, 01<->10): err=1, pos/idx/dir unchanged.
//  Latency: input edge to step pulse = 2 (sync) + DEB_CYCLES (filter) + 1 (decode) cycles.
//  Arithmetic: pos two's complement. WRAP=1: 0x7F+1 -> 0x80, 0x80-1 -> 0x7F (POS_W=8).
//   WRAP=0: hold at 0x7F / 0x80, sat=1 when a step is blocked and stays 1 until pos moves off
//   limit or clr; step_cw/step_ccw still pulse when blocked.
//  idx always wraps modulo NUM_LED (NUM_LED-1 +1 -> 0, 0 -1 -> NUM_LED-1), independent of
//   WRAP/sat; led = 1 << idx, registered, updates same cycle as pos.
//  clr: pos<=0, idx<=0, led<=1, sat<=0 next edge; a step decoded in the same cycle still pulses
//   step_*/dir but does not change pos/idx (clr wins). err unaffected by clr.
//  Outputs are all registered; no combinational path from inputs to outputs.
// TESTING
//  T1 reset: sys_rst=1 2 cycles, inputs toggling -> pos=0, led=8'b0000_0001, no pulses.
//  T2 CW: drive 00,01,11,10,00 each held 10 cycles (DEB=4) -> 4 step_cw pulses, pos=4,
//   led=8'b0001_0000, dir=1; first pulse exactly 7 cycles after in_b rises.
//  T3 CCW from reset: 00,10,11,01,00 -> 4 step_ccw, pos=0xFC, led=8'b0001_0000, dir=0.
//  T4 glitch/illegal: 2-cycle pulse on in_a -> no change; 00->11 held -> one err pulse, pos same.
//  T5 limits: WRAP=1 reach 0x7F then one CW -> pos=0x80; WRAP=0 same -> pos=0x7F, sat=1,
//   step_cw pulses; next CCW -> pos=0x7E, sat=0.
//  T6 clr coincident with CW step at pos=3 -> step_cw pulses, pos=0, led=1; reset mid-sequence
//   (state 11) -> all cleared, next 00->01 is decoded as CW from 00.

Source files
------------

// File: rtl/quad_dir_counter.sv
// Two-channel direction sensor decoder: sync + debounce, Gray-step decode into CW/CCW pulses,
// signed position count (wrap or saturate) and a rotating one-hot LED bar.
module quad_dir_counter #(
  parameter int DEB_CYCLES = 4,
  parameter int POS_W      = 8,
  parameter int NUM_LED    = 8,
  parameter bit WRAP       = 1'b1
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    in_a,
  input  logic                    in_b,
  input  logic                    clr,
  output logic                    step_cw,
  output logic                    step_ccw,
  output logic                    dir,
  output logic                    err,
  output logic                    sat,
  output logic signed [POS_W-1:0] pos,
  output logic [NUM_LED-1:0]      led
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int IDX_W = $clog2(NUM_LED);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_LED - 1);
  localparam logic signed [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic signed [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
  localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);

  logic [1:0]            sync_p0_q, sync_p1_q;
  logic [1:0]            filt_p2_q, filt_p2_d;
  logic [1:0][CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [1:0]            prev_p3_q;
  logic                  cw_w, ccw_w, err_w;
  logic                  step_cw_q, step_cw_d;
  logic                  step_ccw_q, step_ccw_d;
  logic                  dir_q, dir_d;
  logic                  err_q, err_d;
  logic                  sat_q, sat_d;
  logic signed [POS_W-1:0] pos_q, pos_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_LED-1:0]    led_q, led_d;

  // Rank of a state along the CW cycle 00 -> 01 -> 11 -> 10.
  function automatic logic [1:0] gray_rank(input logic [1:0] s);
    return {s[1], s[1] ^ s[0]};
  endfunction

  function automatic logic limit_hit(input logic signed [POS_W-1:0] p, input logic up);
    return (WRAP == 1'b0) && (up ? (p == POS_MAX) : (p == POS_MIN));
  endfunction

  function automatic logic signed [POS_W-1:0] pos_step(input logic signed [POS_W-1:0] p,
                                                       input logic up);
    if (limit_hit(p, up)) return p;
    return up ? (p + POS_ONE) : (p - POS_ONE);
  endfunction

  function automatic logic [IDX_W-1:0] idx_step(input logic [IDX_W-1:0] i, input logic up);
    if (up) return (i == IDX_LAST) ? '0 : (i + IDX_W'(1));
    return (i == '0) ? IDX_LAST : (i - IDX_W'(1));
  endfunction

  // Stage p0/p1: two-flop synchroniser, bit1 = channel A, bit0 = channel B.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync_p0_q <= '0;
      sync_p1_q <= '0;
    end else begin
      sync_p0_q <= {in_a, in_b};
      sync_p1_q <= sync_p0_q;
    end
  end

  // Stage p2: per-channel debounce filter.
  always_comb begin
    filt_p2_d = filt_p2_q;
    deb_cnt_d = deb_cnt_q;
    for (int ch = 0; ch < 2; ch++) begin
      if (sync_p1_q[ch] == filt_p2_q[ch]) begin
        deb_cnt_d[ch] = '0;
      end else if (deb_cnt_q[ch] == CNT_LAST) begin
        filt_p2_d[ch] = sync_p1_q[ch];
        deb_cnt_d[ch] = '0;
      end else begin
        deb_cnt_d[ch] = deb_cnt_q[ch] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      filt_p2_q <= '0;
      deb_cnt_q <= '0;
      prev_p3_q <= '0;
    end else begin
      filt_p2_q <= filt_p2_d;
      deb_cnt_q <= deb_cnt_d;
      prev_p3_q <= filt_p2_q;
    end
  end

  // Stage p3: step decode against the previous filtered state.
  assign cw_w  = (gray_rank(filt_p2_q) == (gray_rank(prev_p3_q) + 2'd1));
  assign ccw_w = (gray_rank(prev_p3_q) == (gray_rank(filt_p2_q) + 2'd1));
  assign err_w = ((filt_p2_q ^ prev_p3_q) == 2'b11);

  always_comb begin
    step_cw_d  = cw_w;
    step_ccw_d = ccw_w;
    err_d      = err_w;
    dir_d      = dir_q;
    pos_d      = pos_q;
    idx_d      = idx_q;
    sat_d      = sat_q;
    if (cw_w)  dir_d = 1'b1;
    if (ccw_w) dir_d = 1'b0;
    if (clr) begin
      pos_d = '0;
      idx_d = '0;
      sat_d = 1'b0;
    end else if (cw_w || ccw_w) begin
      sat_d = limit_hit(pos_q, cw_w);
      pos_d = pos_step(pos_q, cw_w);
      idx_d = idx_step(idx_q, cw_w);
    end
    led_d = NUM_LED'(1) << idx_d;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      step_cw_q  <= 1'b0;
      step_ccw_q <= 1'b0;
      err_q      <= 1'b0;
      dir_q      <= 1'b0;
      sat_q      <= 1'b0;
      pos_q      <= '0;
      idx_q      <= '0;
      led_q      <= NUM_LED'(1);
    end else begin
      step_cw_q  <= step_cw_d;
      step_ccw_q <= step_ccw_d;
      err_q      <= err_d;
      dir_q      <= dir_d;
      sat_q      <= sat_d;
      pos_q      <= pos_d;
      idx_q      <= idx_d;
      led_q      <= led_d;
    end
  end

  assign step_cw  = step_cw_q;
  assign step_ccw = step_ccw_q;
  assign dir      = dir_q;
  assign err      = err_q;
  assign sat      = sat_q;
  assign pos      = pos_q;
  assign led      = led_q;

endmodule

// File: tb/tb_quad_dir_counter.sv
// Bench for quad_dir_counter: a wrapping and a saturating instance share stimulus and are
// checked every cycle against a sample-history model, plus literal checks per scenario.
module tb_quad_dir_counter;

  localparam int DEB   = 4;
  localparam int POS_W = 8;
  localparam int NLED  = 8;
  localparam int PMAX  = (1 << (POS_W - 1)) - 1;
  localparam int PMIN  = -(1 << (POS_W - 1));

  logic clk = 1'b0;
  logic sys_rst, in_a, in_b, clr;
  logic [1:0] o_cw, o_ccw, o_dir, o_err, o_sat;
  logic [POS_W-1:0] o_pos [2];
  logic [NLED-1:0]  o_led [2];

  int n_vec = 0;
  int n_mis = 0;
  int cw_cnt = 0, ccw_cnt = 0, err_cnt = 0, sat_cw_cnt = 0, first_cw = 0;
  int cur_g = 0;
  int c0, c1, c2;
  logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  always #5 clk = ~clk;

  quad_dir_counter #(.DEB_CYCLES(DEB), .POS_W(POS_W), .NUM_LED(NLED), .WRAP(1'b1)) u_wrap (
    .sys_clk(clk), .sys_rst(sys_rst), .in_a(in_a), .in_b(in_b), .clr(clr),
    .step_cw(o_cw[0]), .step_ccw(o_ccw[0]), .dir(o_dir[0]), .err(o_err[0]),
    .sat(o_sat[0]), .pos(o_pos[0]), .led(o_led[0]));

  quad_dir_counter #(.DEB_CYCLES(DEB), .POS_W(POS_W), .NUM_LED(NLED), .WRAP(1'b0)) u_sat (
    .sys_clk(clk), .sys_rst(sys_rst), .in_a(in_a), .in_b(in_b), .clr(clr),
    .step_cw(o_cw[1]), .step_ccw(o_ccw[1]), .dir(o_dir[1]), .err(o_err[1]),
    .sat(o_sat[1]), .pos(o_pos[1]), .led(o_led[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pat(input int p);
    return 32'(p) & ((32'd1 << POS_W) - 32'd1);
  endfunction

  function automatic int gidx(input logic [1:0] v);
    for (int i = 0; i < 4; i++) if (seq[i] == v) return i;
    return 0;
  endfunction

  // Model: the accepted value of a channel is whatever the last DEB synchronised samples
  // agree on; steps are the signed distance between successive accepted states.
  logic [1:0] hist [$];
  logic [1:0] m_filt, m_prev, hv;
  bit m_live = 0, m_cw, m_ccw, m_err, m_dir, uni, bv;
  bit m_sat [2];
  int m_pos [2];
  int m_idx, md, mst, mt, hs;

  always @(posedge clk) begin
    if (sys_rst) begin
      hist.delete();
      for (int k = 0; k <= DEB; k++) hist.push_back(2'b00);
      m_filt = 2'b00; m_prev = 2'b00;
      m_cw = 0; m_ccw = 0; m_err = 0; m_dir = 0;
      m_pos[0] = 0; m_pos[1] = 0; m_sat[0] = 0; m_sat[1] = 0; m_idx = 0;
      m_live = 1;
    end else if (m_live) begin
      md = (gidx(m_filt) - gidx(m_prev) + 4) % 4;
      m_cw = (md == 1); m_ccw = (md == 3); m_err = (md == 2);
      if (m_cw) m_dir = 1;
      if (m_ccw) m_dir = 0;
      if (clr) begin
        m_pos[0] = 0; m_pos[1] = 0; m_sat[0] = 0; m_sat[1] = 0; m_idx = 0;
      end else if (m_cw || m_ccw) begin
        mst = m_cw ? 1 : -1;
        m_idx = (m_idx + mst + NLED) % NLED;
        for (int w = 0; w < 2; w++) begin
          mt = m_pos[w] + mst;
          if (w == 0) begin
            if (mt > PMAX) mt = mt - (1 << POS_W);
            if (mt < PMIN) mt = mt + (1 << POS_W);
            m_pos[w] = mt;
          end else if (mt > PMAX || mt < PMIN) begin
            m_sat[w] = 1;
          end else begin
            m_pos[w] = mt;
            m_sat[w] = 0;
          end
        end
      end
      m_prev = m_filt;
      hs = hist.size();
      for (int b = 0; b < 2; b++) begin
        hv = hist[hs-2];
        bv = hv[b];
        uni = 1;
        for (int k = 1; k < DEB; k++) begin
          hv = hist[hs-2-k];
          if (hv[b] != bv) uni = 0;
        end
        if (uni) m_filt[b] = bv;
      end
      hist.push_back({in_a, in_b});
      if (hist.size() > DEB + 4) void'(hist.pop_front());
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      for (int w = 0; w < 2; w++) begin
        chk($sformatf("cw%0d", w),  o_cw[w],  m_cw);
        chk($sformatf("ccw%0d", w), o_ccw[w], m_ccw);
        chk($sformatf("dir%0d", w), o_dir[w], m_dir);
        chk($sformatf("err%0d", w), o_err[w], m_err);
        chk($sformatf("sat%0d", w), o_sat[w], m_sat[w]);
        chk($sformatf("pos%0d", w), o_pos[w], pat(m_pos[w]));
        chk($sformatf("led%0d", w), o_led[w], 32'(1) << m_idx);
      end
    end
  end

  task automatic hold(input logic [1:0] ab, input int n);
    in_a = ab[1]; in_b = ab[0]; first_cw = 0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (o_cw[0]) begin
        cw_cnt++;
        if (first_cw == 0) first_cw = c;
      end
      if (o_ccw[0]) ccw_cnt++;
      if (o_err[0]) err_cnt++;
      if (o_cw[1])  sat_cw_cnt++;
    end
  endtask

  task automatic do_cw();
    cur_g = (cur_g + 1) % 4;
    hold(seq[cur_g], 8);
  endtask

  task automatic do_ccw();
    cur_g = (cur_g + 3) % 4;
    hold(seq[cur_g], 8);
  endtask

  task automatic do_reset();
    sys_rst = 1; hold(2'b00, 2); sys_rst = 0; hold(2'b00, 10); cur_g = 0;
  endtask

  initial begin
    sys_rst = 1; clr = 0; in_a = 0; in_b = 0;
    // T1: reset with inputs toggling
    hold(2'b10, 1); hold(2'b01, 1); hold(2'b11, 1);
    chk("T1 pos", o_pos[0], 32'h0);
    chk("T1 led", o_led[0], 32'h01);
    chk("T1 pulses", {o_cw[0], o_ccw[0], o_err[0]}, 32'h0);
    hold(2'b00, 2);
    sys_rst = 0; hold(2'b00, 10);

    // T2: full CW cycle
    c0 = cw_cnt;
    hold(2'b01, 10);
    chk("T2 latency", first_cw, 7);
    hold(2'b11, 10); hold(2'b10, 10); hold(2'b00, 10);
    chk("T2 cw count", cw_cnt - c0, 4);
    chk("T2 pos", o_pos[0], 32'h04);
    chk("T2 model pos", pat(m_pos[0]), 32'h04);
    chk("T2 led", o_led[0], 32'h10);
    chk("T2 dir", o_dir[0], 32'h1);

    // T3: CCW cycle from reset
    do_reset();
    c0 = ccw_cnt;
    hold(2'b10, 10); hold(2'b11, 10); hold(2'b01, 10); hold(2'b00, 10);
    chk("T3 ccw count", ccw_cnt - c0, 4);
    chk("T3 pos", o_pos[0], 32'hFC);
    chk("T3 model pos", pat(m_pos[0]), 32'hFC);
    chk("T3 led", o_led[0], 32'h10);
    chk("T3 dir", o_dir[0], 32'h0);

    // T4: short glitch, then an illegal two-bit change
    c0 = cw_cnt + ccw_cnt; c1 = err_cnt;
    hold(2'b10, 2); hold(2'b00, 10);
    chk("T4 glitch steps", cw_cnt + ccw_cnt - c0, 0);
    chk("T4 glitch err", err_cnt - c1, 0);
    hold(2'b11, 12);
    chk("T4 err count", err_cnt - c1, 1);
    chk("T4 pos", o_pos[0], 32'hFC);
    chk("T4 steps", cw_cnt + ccw_cnt - c0, 0);
    hold(2'b00, 12);
    chk("T4 err back", err_cnt - c1, 2);

    // T5: upper limit, wrapping vs saturating
    do_reset();
    for (int i = 0; i < PMAX; i++) do_cw();
    chk("T5 pos wrap @max", o_pos[0], 32'h7F);
    chk("T5 pos sat @max", o_pos[1], 32'h7F);
    chk("T5 sat before", o_sat[1], 32'h0);
    c2 = sat_cw_cnt;
    do_cw();
    chk("T5 wrap pos", o_pos[0], 32'h80);
    chk("T5 model wrap pos", pat(m_pos[0]), 32'h80);
    chk("T5 sat pos", o_pos[1], 32'h7F);
    chk("T5 sat flag", o_sat[1], 32'h1);
    chk("T5 wrap sat flag", o_sat[0], 32'h0);
    chk("T5 blocked cw pulse", sat_cw_cnt - c2, 1);
    do_ccw();
    chk("T5 sat pos back", o_pos[1], 32'h7E);
    chk("T5 sat flag off", o_sat[1], 32'h0);
    chk("T5 wrap pos back", o_pos[0], 32'h7F);

    // T6: clr coincident with a step, then reset mid-sequence
    do_reset();
    do_cw(); do_cw(); do_cw();
    chk("T6 pos 3", o_pos[0], 32'h03);
    cur_g = (cur_g + 1) % 4;
    in_a = seq[cur_g][1]; in_b = seq[cur_g][0];
    repeat (6) @(negedge clk);
    clr = 1;
    @(negedge clk);
    chk("T6 clr step pulse", o_cw[0], 32'h1);
    chk("T6 clr pos", o_pos[0], 32'h0);
    chk("T6 clr led", o_led[0], 32'h01);
    chk("T6 clr dir", o_dir[0], 32'h1);
    clr = 0;
    hold(seq[cur_g], 4);
    do_cw(); do_cw();
    chk("T6 pos 2", o_pos[0], 32'h02);
    sys_rst = 1; hold(2'b00, 2); sys_rst = 0;
    chk("T6 rst pos", o_pos[0], 32'h0);
    chk("T6 rst led", o_led[0], 32'h01);
    chk("T6 rst dir", o_dir[0], 32'h0);
    hold(2'b00, 10); cur_g = 0;
    c0 = cw_cnt;
    do_cw();
    chk("T6 cw after rst", cw_cnt - c0, 1);
    chk("T6 pos 1", o_pos[0], 32'h01);
    chk("T6 led 1", o_led[0], 32'h02);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
